// File: rtl/decision_level_tracker.sv
// ---------------------------------------------------------------------------
// decision_level_tracker
//
// Decision-level counter for the CDCL control FSM. It supports three commands:
//   - decide: the level goes up by one.
//   - backtrack: the level goes down by one, which is a chronological backtrack.
//   - backjump: the level drops to a lower target level. This unwinds one level
//     per cycle and emits an undo strobe for each retracted level.
// Sticky flags record overflow, underflow and illegal jump attempts.
//
// Ports
//   clk           clock, all state updates on posedge
//   rst           asynchronous active-low reset
//   en            command strobe, accepted when en && !busy
//   cmd           00 nop, 01 decide, 10 backtrack, 11 backjump
//   target_level  backjump destination, sampled on an accepted backjump
//   clr_err       synchronous clear of the sticky error flags
//   level         current decision level
//   busy          high while a backjump is unwinding
//   undo_valid    one-cycle strobe: undo_level is being retracted
//   undo_level    level being retracted
//   done          one-cycle pulse when a backtrack/backjump completes
//   at_root       level == 0
//   at_max        level == LITERALS
//   ovf_err       sticky: decide attempted at LITERALS
//   unf_err       sticky: backtrack attempted at level 0
//   jump_err      sticky: backjump target above current level
// ---------------------------------------------------------------------------
module decision_level_tracker #(
    parameter int LITERALS = 8,
    parameter int LW       = $clog2(LITERALS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    cmd,
    input  logic [LW-1:0] target_level,
    input  logic          clr_err,
    output logic [LW-1:0] level,
    output logic          busy,
    output logic          undo_valid,
    output logic [LW-1:0] undo_level,
    output logic          done,
    output logic          at_root,
    output logic          at_max,
    output logic          ovf_err,
    output logic          unf_err,
    output logic          jump_err
);

    localparam logic [LW-1:0] MAX_LVL = LW'(LITERALS);
    localparam logic [LW-1:0] ONE     = LW'(1);
    localparam logic [LW-1:0] ZERO    = '0;

    localparam logic [1:0] CMD_DECIDE    = 2'b01;
    localparam logic [1:0] CMD_BACKTRACK = 2'b10;
    localparam logic [1:0] CMD_BACKJUMP  = 2'b11;

    typedef enum logic {IDLE, UNWIND} state_t;

    state_t        state;
    logic [LW-1:0] tgt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            level      <= ZERO;
            tgt        <= ZERO;
            undo_valid <= 1'b0;
            undo_level <= ZERO;
            done       <= 1'b0;
            ovf_err    <= 1'b0;
            unf_err    <= 1'b0;
            jump_err   <= 1'b0;
        end else begin
            undo_valid <= 1'b0;
            done       <= 1'b0;

            // A clear and a new error on the same edge resolve in favour of
            // the error, because the later set below overrides this clear.
            if (clr_err) begin
                ovf_err  <= 1'b0;
                unf_err  <= 1'b0;
                jump_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (en) begin
                        case (cmd)
                            CMD_DECIDE: begin
                                if (level == MAX_LVL) ovf_err <= 1'b1;
                                else                  level   <= level + ONE;
                            end
                            CMD_BACKTRACK: begin
                                if (level == ZERO) begin
                                    unf_err <= 1'b1;
                                end else begin
                                    level      <= level - ONE;
                                    undo_valid <= 1'b1;
                                    undo_level <= level;
                                    done       <= 1'b1;
                                end
                            end
                            CMD_BACKJUMP: begin
                                if (target_level > level) begin
                                    jump_err <= 1'b1;
                                end else if (target_level == level) begin
                                    done <= 1'b1;
                                end else begin
                                    // The entry edge only latches the target.
                                    // Retraction starts on the next edge.
                                    tgt   <= target_level;
                                    state <= UNWIND;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                UNWIND: begin
                    // Retract one level per edge in strictly descending order.
                    // Commands are ignored in this state.
                    undo_valid <= 1'b1;
                    undo_level <= level;
                    level      <= level - ONE;
                    if ((level - ONE) == tgt) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state == UNWIND);
    assign at_root = (level == ZERO);
    assign at_max  = (level == MAX_LVL);

endmodule

// File: tb/tb_decision_level_tracker.sv
module tb_decision_level_tracker;

    localparam int LW = 4;

    logic          clk;
    logic          rst;
    logic          en;
    logic [1:0]    cmd;
    logic [LW-1:0] target_level;
    logic          clr_err;
    logic [LW-1:0] level;
    logic          busy;
    logic          undo_valid;
    logic [LW-1:0] undo_level;
    logic          done;
    logic          at_root;
    logic          at_max;
    logic          ovf_err;
    logic          unf_err;
    logic          jump_err;

    int checks = 0;
    int errors = 0;

    // Scoreboard of expected undo_level values, in the order they must appear.
    logic [LW-1:0] sb_q[$];

    decision_level_tracker #(.LITERALS(8)) dut (
        .clk(clk), .rst(rst), .en(en), .cmd(cmd), .target_level(target_level),
        .clr_err(clr_err), .level(level), .busy(busy), .undo_valid(undo_valid),
        .undo_level(undo_level), .done(done), .at_root(at_root), .at_max(at_max),
        .ovf_err(ovf_err), .unf_err(unf_err), .jump_err(jump_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [1:0] c, input logic [LW-1:0] t);
        en = 1'b1; cmd = c; target_level = t;
        tick();
        en = 1'b0; cmd = 2'b00;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        sb_q.delete();
    endtask

    task automatic go_level(input int n);
        reset_pulse();
        for (int i = 0; i < n; i++) do_cmd(2'b01, '0);
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; cmd = 2'b00; target_level = '0; clr_err = 1'b0;
        tick(); tick();
        checks++;
        if (level !== 4'd0 || busy !== 1'b0 || at_root !== 1'b1 || at_max !== 1'b0 ||
            undo_valid !== 1'b0 || undo_level !== 4'd0 || done !== 1'b0 ||
            ovf_err !== 1'b0 || unf_err !== 1'b0 || jump_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: level=%0d busy=%b root=%b max=%b uv=%b ul=%0d done=%b errs=%b%b%b required level=0 busy=0 root=1 max=0 uv=0 ul=0 done=0 errs=000",
                     level, busy, at_root, at_max, undo_valid, undo_level, done, ovf_err, unf_err, jump_err);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_decide_ovf();
        reset_pulse();
        for (int i = 1; i <= 8; i++) begin
            do_cmd(2'b01, '0);
            checks++;
            if (level !== LW'(i) || undo_valid !== 1'b0) begin
                errors++;
                $display("FAIL decide_step%0d: level=%0d uv=%b required level=%0d uv=0", i, level, undo_valid, i);
            end
        end
        checks++;
        if (at_max !== 1'b1 || at_root !== 1'b0) begin
            errors++;
            $display("FAIL at_max: at_max=%b at_root=%b required 1 0", at_max, at_root);
        end
        do_cmd(2'b01, '0);
        checks++;
        if (level !== 4'd8 || ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL decide_ovf: level=%0d ovf=%b required level=8 ovf=1", level, ovf_err);
        end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        checks++;
        if (ovf_err !== 1'b0 || level !== 4'd8) begin
            errors++;
            $display("FAIL clr_ovf: ovf=%b level=%0d required ovf=0 level=8", ovf_err, level);
        end
    endtask

    task automatic test_underflow();
        bit seen_uv = 0;
        bit seen_done = 0;
        reset_pulse();
        do_cmd(2'b10, '0);
        if (undo_valid) seen_uv = 1;
        if (done) seen_done = 1;
        checks++;
        if (level !== 4'd0 || unf_err !== 1'b1) begin
            errors++;
            $display("FAIL backtrack_unf: level=%0d unf=%b required level=0 unf=1", level, unf_err);
        end
        // A new error on the same edge as clr_err keeps the flag set.
        clr_err = 1'b1;
        do_cmd(2'b10, '0);
        clr_err = 1'b0;
        if (undo_valid) seen_uv = 1;
        if (done) seen_done = 1;
        checks++;
        if (unf_err !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_set: unf=%b required 1", unf_err);
        end
        tick();
        if (undo_valid) seen_uv = 1;
        if (done) seen_done = 1;
        checks++;
        if (seen_uv || seen_done) begin
            errors++;
            $display("FAIL unf_no_undo: undo_seen=%b done_seen=%b required 0 0", seen_uv, seen_done);
        end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        checks++;
        if (unf_err !== 1'b0) begin
            errors++;
            $display("FAIL clr_unf: unf=%b required 0", unf_err);
        end
    endtask

    task automatic test_backtrack();
        logic [LW-1:0] exp;
        go_level(5);
        sb_q.push_back(4'd5);
        do_cmd(2'b10, '0);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        checks++;
        if (level !== 4'd4 || undo_valid !== 1'b1 || undo_level !== exp || done !== 1'b1) begin
            errors++;
            $display("FAIL backtrack: level=%0d uv=%b ul=%0d done=%b required level=4 uv=1 ul=%0d done=1",
                     level, undo_valid, undo_level, done, exp);
        end
        tick();
        checks++;
        if (undo_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL backtrack_pulse: uv=%b done=%b required 0 0", undo_valid, done);
        end
    endtask

    task automatic test_backjump();
        logic [LW-1:0] exp;
        int  edges = 0;
        int  busy_cnt = 0;
        bit  got_done = 0;
        go_level(7);
        for (int l = 7; l > 2; l--) sb_q.push_back(LW'(l));
        do_cmd(2'b11, 4'd2);
        edges = 1;
        checks++;
        if (busy !== 1'b1 || undo_valid !== 1'b0) begin
            errors++;
            $display("FAIL backjump_entry: busy=%b uv=%b required busy=1 uv=0", busy, undo_valid);
        end
        for (int c = 0; c < 12 && !got_done; c++) begin
            if (busy) busy_cnt++;
            en = 1'b1; cmd = 2'b01;  // decides while busy must be ignored
            tick();
            edges++;
            if (undo_valid) begin
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
                checks++;
                if (undo_level !== exp) begin
                    errors++;
                    $display("FAIL backjump_undo: undo_level=%0d required %0d", undo_level, exp);
                end
            end
            if (done) got_done = 1;
        end
        en = 1'b0; cmd = 2'b00;
        checks++;
        if (!got_done || edges != 6 || busy_cnt != 5) begin
            errors++;
            $display("FAIL backjump_done: done_seen=%b edges=%0d busy_cycles=%0d required 1 6 5", got_done, edges, busy_cnt);
        end
        checks++;
        if (undo_level !== 4'd3 || level !== 4'd2 || busy !== 1'b0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL backjump_end: ul=%0d level=%0d busy=%b left=%0d required ul=3 level=2 busy=0 left=0",
                     undo_level, level, busy, sb_q.size());
        end
        tick();
        checks++;
        if (level !== 4'd2 || ovf_err !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL backjump_after: level=%0d ovf=%b done=%b required 2 0 0", level, ovf_err, done);
        end
    endtask

    task automatic test_jump_edges();
        go_level(3);
        do_cmd(2'b11, 4'd3);
        checks++;
        if (done !== 1'b1 || undo_valid !== 1'b0 || busy !== 1'b0 || level !== 4'd3) begin
            errors++;
            $display("FAIL jump_same: done=%b uv=%b busy=%b level=%0d required 1 0 0 3", done, undo_valid, busy, level);
        end
        do_cmd(2'b11, 4'd6);
        checks++;
        if (jump_err !== 1'b1 || level !== 4'd3 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL jump_err: jerr=%b level=%0d done=%b busy=%b required 1 3 0 0", jump_err, level, done, busy);
        end
    endtask

    task automatic test_reset_mid_unwind();
        logic [LW-1:0] exp;
        int  strobes = 0;
        bit  late = 0;
        go_level(6);
        for (int l = 6; l > 0; l--) sb_q.push_back(LW'(l));
        do_cmd(2'b11, 4'd0);
        for (int c = 0; c < 10 && strobes < 2; c++) begin
            tick();
            if (undo_valid) begin
                strobes++;
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
                checks++;
                if (undo_level !== exp) begin
                    errors++;
                    $display("FAIL unwind_undo: undo_level=%0d required %0d", undo_level, exp);
                end
            end
        end
        checks++;
        if (strobes != 2) begin
            errors++;
            $display("FAIL unwind_strobes: strobes=%0d required 2", strobes);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (level !== 4'd0 || busy !== 1'b0 || undo_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: level=%0d busy=%b uv=%b done=%b required 0 0 0 0", level, busy, undo_valid, done);
        end
        #1;
        rst = 1'b1;
        sb_q.delete();
        for (int c = 0; c < 10; c++) begin
            tick();
            if (undo_valid || done || busy) late = 1;
        end
        checks++;
        if (late || level !== 4'd0) begin
            errors++;
            $display("FAIL post_reset: activity=%b level=%0d required 0 0", late, level);
        end
    endtask

    task automatic test_back_to_back();
        logic [LW-1:0] exp;
        logic [LW-1:0] exp_lvl[5] = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1};
        reset_pulse();
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmd = (i < 3) ? 2'b01 : 2'b10;
            if (i >= 3) sb_q.push_back(LW'(6 - i));
            tick();
            checks++;
            if (level !== exp_lvl[i]) begin
                errors++;
                $display("FAIL b2b_level%0d: level=%0d required %0d", i, level, exp_lvl[i]);
            end
            if (i >= 3) begin
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
                checks++;
                if (undo_valid !== 1'b1 || undo_level !== exp || done !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_undo%0d: uv=%b ul=%0d done=%b required 1 %0d 1", i, undo_valid, undo_level, done, exp);
                end
            end
        end
        en = 1'b0; cmd = 2'b00;
    endtask

    initial begin
        test_reset();
        test_decide_ovf();
        test_underflow();
        test_backtrack();
        test_backjump();
        test_jump_edges();
        test_reset_mid_unwind();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
